// File: rtl/wide_add_sequencer_pkg.sv
// Shared types for the wide add/subtract sequencer.
package wide_add_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seqState_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, the building block of the chunk ripple-carry chain.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/wide_add_sequencer_rca_cin.sv
// W-bit ripple-carry adder with carry in/out, one full_adder per bit.
module rca_cin #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0] carry;

  assign carry[0] = cin_i;
  assign cout_o   = carry[W];

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a_i    (a_i[i]),
      .b_i    (b_i[i]),
      .cin_i  (carry[i]),
      .sum_o  (sum_o[i]),
      .cout_o (carry[i+1])
    );
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// N = W*K bit add/subtract built by running one W-bit chunk adder over K cycles,
// with the inter-chunk carry held in a register between cycles.
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int W = 16,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W*K-1:0] a,
  input  logic [W*K-1:0] b,
  input  logic           sub,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W*K-1:0] sum,
  output logic           carry_out,
  output logic           busy
);

  localparam int N  = W * K;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  seqState_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          sub_q, sub_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;

  logic [W-1:0]  aChunk;
  logic [W-1:0]  bChunk;
  logic [W-1:0]  chunkSum;
  logic          chunkCout;

  // Subtraction is a + ~b + 1: B is inverted per chunk and the +1 enters as the initial carry.
  assign aChunk = a_q[int'(idx_q)*W +: W];
  assign bChunk = b_q[int'(idx_q)*W +: W] ^ {W{sub_q}};

  rca_cin #(
    .W (W)
  ) u_rca (
    .a_i    (aChunk),
    .b_i    (bChunk),
    .cin_i  (carry_q),
    .sum_o  (chunkSum),
    .cout_o (chunkCout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          idx_d   = '0;
          carry_d = sub;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(idx_q)*W +: W] = chunkSum;
        carry_d = chunkCout;
        if (idx_q == IW'(K - 1)) begin
          cout_d  = chunkCout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed and randomized checks of wide_add_sequencer with W=4, K=4 (16-bit operands).
module tb_wide_add_sequencer;

  localparam int W = 4;
  localparam int K = 4;
  localparam int N = W * K;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         carry_out;
  logic         busy;

  int compareCount;
  int mismatchCount;
  int latency;
  int resultCount;

  wide_add_sequencer #(
    .W (W),
    .K (K)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Present operands and complete the input handshake; latency counts the accept edge as 1.
  task automatic applyStimulus(input logic [N-1:0] aVal, input logic [N-1:0] bVal, input logic subVal);
    int waitCycles;
    @(negedge clk);
    a        = aVal;
    b        = bVal;
    sub      = subVal;
    in_valid = 1'b1;
    waitCycles = 0;
    while (!in_ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("in_ready_at_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    latency  = 1;
  endtask

  task automatic waitResult(input string tag, input logic [N-1:0] expSum, input logic expCout);
    int waitCycles;
    waitCycles = 0;
    forever begin
      @(negedge clk);
      if (out_valid || waitCycles >= 20) break;
      @(posedge clk);
      latency++;
      waitCycles++;
    end
    checkOutput({tag, "_valid"}, out_valid, 1);
    checkOutput({tag, "_latency"}, latency, K + 1);
    checkOutput({tag, "_sum"}, sum, expSum);
    checkOutput({tag, "_cout"}, carry_out, expCout);
  endtask

  task automatic consumeResult(input string tag, input bit randomReady);
    int  waitCycles;
    bit  taken;
    logic [N-1:0] heldSum;
    logic         heldCout;
    heldSum    = sum;
    heldCout   = carry_out;
    taken      = 1'b0;
    waitCycles = 0;
    while (!taken && waitCycles < 50) begin
      @(negedge clk);
      if (randomReady) out_ready = 1'($urandom_range(0, 1));
      else             out_ready = 1'b1;
      if (sum !== heldSum || carry_out !== heldCout) begin
        checkOutput({tag, "_held_sum"}, sum, heldSum);
      end
      taken = out_ready && out_valid;
      @(posedge clk);
      waitCycles++;
    end
    #1;
    out_ready = 1'b0;
    if (taken) resultCount++;
    checkOutput({tag, "_taken"}, taken, 1);
    checkOutput({tag, "_no_dup"}, out_valid, 0);
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic         rs;
    logic [N:0]   model;

    compareCount  = 0;
    mismatchCount = 0;
    resultCount   = 0;
    latency       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a   = '0;
    b   = '0;
    sub = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_sum", sum, 0);
    checkOutput("rst_cout", carry_out, 0);
    rst = 1'b0;

    $display("[TB] directed add/sub vectors");
    applyStimulus(16'h00FF, 16'h0001, 1'b0);
    checkOutput("add1_busy", busy, 1);
    waitResult("add1", 16'h0100, 1'b0);
    consumeResult("add1", 1'b0);

    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    waitResult("add2", 16'h0000, 1'b1);
    consumeResult("add2", 1'b0);

    applyStimulus(16'h0005, 16'h0007, 1'b1);
    waitResult("sub1", 16'hFFFE, 1'b0);
    consumeResult("sub1", 1'b0);

    applyStimulus(16'h0007, 16'h0005, 1'b1);
    waitResult("sub2", 16'h0002, 1'b1);
    consumeResult("sub2", 1'b0);

    $display("[TB] backpressure in DONE");
    applyStimulus(16'h8000, 16'h8000, 1'b0);
    waitResult("bp", 16'h0000, 1'b1);
    a        = 16'h1000;
    b        = 16'h0234;
    sub      = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_sum", sum, 16'h0000);
      checkOutput("bp_cout", carry_out, 1);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_out_valid", out_valid, 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    resultCount++;
    checkOutput("bp_release_in_ready", in_ready, 1);
    checkOutput("bp_release_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    latency  = 1;
    waitResult("bp_next", 16'h1234, 1'b0);
    consumeResult("bp_next", 1'b0);

    $display("[TB] reset in the middle of RUN");
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_sum", sum, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'h1234, 16'h1111, 1'b0);
    waitResult("after_rst", 16'h2345, 1'b0);
    consumeResult("after_rst", 1'b0);

    $display("[TB] random back-to-back operations");
    for (int n = 0; n < 200; n++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rs = 1'($urandom_range(0, 1));
      model = {1'b0, ra} + {1'b0, (rs ? ~rb : rb)} + {{N{1'b0}}, rs};
      applyStimulus(ra, rb, rs);
      waitResult("rand", model[N-1:0], model[N]);
      consumeResult("rand", 1'b1);
    end
    checkOutput("result_count", resultCount, 207);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
